// File: rtl/shift_register_param_if.sv
// shift_register_param_if: command/status bundle for shift_register_param; zero exists only with SHREG_ZERO_FLAG_EN
interface shift_register_param_if #(
  parameter int WIDTH = 32,
  parameter int AMT_W = $clog2(WIDTH) + 1
);
  logic [2:0]       mode;
  logic [WIDTH-1:0] load_val;
  logic             ser_in;
  logic             start;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] q;
  logic             ser_out;
  logic             busy;
  logic             done;
`ifdef SHREG_ZERO_FLAG_EN
  logic             zero;
`endif
  modport master (
    output mode, load_val, ser_in, start, amount,
    input  q, ser_out, busy, done
`ifdef SHREG_ZERO_FLAG_EN
    , input zero
`endif
  );
  modport slave (
    input  mode, load_val, ser_in, start, amount,
    output q, ser_out, busy, done
`ifdef SHREG_ZERO_FLAG_EN
    , output zero
`endif
  );
endinterface

// File: rtl/shift_register_param.sv
// shift_register_param: shift/rotate/load register with multi-cycle shift-by-N, updating on negedge clk; SHREG_ZERO_FLAG_EN adds a registered zero flag
module shift_register_param #(
  parameter int WIDTH = 32,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input logic                  clk,
  input logic                  r,
  shift_register_param_if.slave s
);
  localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SLL = 3'd2, SRL = 3'd3;
  localparam logic [2:0] SRA = 3'd4, ROL = 3'd5, ROR = 3'd6, CLR = 3'd7;
  logic [WIDTH-1:0] r_q, w_op_q, w_q_next;
  logic [AMT_W-1:0] r_cnt;
  logic [2:0]       r_mode, w_op;
  logic             r_ser_out, r_busy, r_done;
  logic             w_out, w_shift, w_launch, w_skip;
  assign w_op     = r_busy ? r_mode : s.mode;
  assign w_shift  = w_op inside {SLL, SRL, SRA, ROL, ROR};
  assign w_launch = ~r_busy & s.start & w_shift;
  assign w_skip   = w_launch & (s.amount == '0);
  assign w_q_next = w_skip ? r_q : w_op_q;
  // one application of the active operation and the bit it pushes out of q
  always_comb begin
    w_op_q = r_q;
    w_out  = 1'b0;
    case (w_op)
      LOAD: w_op_q = s.load_val;
      SLL: begin w_op_q = {r_q[WIDTH-2:0], s.ser_in}; w_out = r_q[WIDTH-1]; end
      SRL: begin w_op_q = {s.ser_in, r_q[WIDTH-1:1]}; w_out = r_q[0]; end
      SRA: begin w_op_q = {r_q[WIDTH-1], r_q[WIDTH-1:1]}; w_out = r_q[0]; end
      ROL: begin w_op_q = {r_q[WIDTH-2:0], r_q[WIDTH-1]}; w_out = r_q[WIDTH-1]; end
      ROR: begin w_op_q = {r_q[0], r_q[WIDTH-1:1]}; w_out = r_q[0]; end
      CLR: w_op_q = '0;
      default: w_op_q = r_q;
    endcase
  end
  // data register plus step counter; a launch performs its first step on the same edge
  always_ff @(negedge clk) begin
    if (r) begin
      r_q       <= '0;
      r_ser_out <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cnt     <= '0;
      r_mode    <= HOLD;
    end else begin
      r_q       <= w_q_next;
      r_ser_out <= (w_shift & ~w_skip) ? w_out : r_ser_out;
      if (r_busy) begin
        r_cnt  <= r_cnt - AMT_W'(1);
        r_busy <= r_cnt != AMT_W'(1);
        r_done <= r_cnt == AMT_W'(1);
      end else if (w_launch) begin
        r_mode <= s.mode;
        r_cnt  <= w_skip ? '0 : s.amount - AMT_W'(1);
        r_busy <= s.amount > AMT_W'(1);
        r_done <= s.amount <= AMT_W'(1);
      end else begin
        r_done <= 1'b0;
      end
    end
  end
  assign s.q       = r_q;
  assign s.ser_out = r_ser_out;
  assign s.busy    = r_busy;
  assign s.done    = r_done;
`ifdef SHREG_ZERO_FLAG_EN
  logic r_zero;
  // flags an all-zero value as it is written into q
  always_ff @(negedge clk) begin
    r_zero <= r ? 1'b1 : (w_q_next == '0);
  end
  assign s.zero = r_zero;
`endif
endmodule

// File: tb/tb_shift_register_param.sv
// tb_shift_register_param: directed self-checking bench for shift_register_param at WIDTH=8
module tb_shift_register_param;
  logic clk;
  logic r;
  int   n_chk = 0;
  int   n_err = 0;
  shift_register_param_if #(.WIDTH(8), .AMT_W(4)) sif ();
  shift_register_param #(.WIDTH(8), .AMT_W(4)) dut (.clk(clk), .r(r), .s(sif.slave));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [2:0] m, input logic [7:0] lv, input logic si, input logic st, input logic [3:0] amt);
    sif.mode = m; sif.load_val = lv; sif.ser_in = si; sif.start = st; sif.amount = amt;
  endtask
  initial begin
    r = 1'b1;
    drive(3'd0, 8'h00, 1'b0, 1'b0, 4'd0);
    tick; tick;
    chk("rst_q", sif.q, 8'h00);
    chk("rst_ser", 8'(sif.ser_out), 8'h0);
    chk("rst_busy", 8'(sif.busy), 8'h0);
    chk("rst_done", 8'(sif.done), 8'h0);
`ifdef SHREG_ZERO_FLAG_EN
    chk("rst_zero", 8'(sif.zero), 8'h1);
`endif
    r = 1'b0;
    drive(3'd1, 8'hB4, 1'b0, 1'b0, 4'd0); tick;
    chk("load_b4", sif.q, 8'hB4);
    drive(3'd4, 8'h00, 1'b0, 1'b0, 4'd0); tick;
    chk("sra_q", sif.q, 8'hDA);
    chk("sra_ser", 8'(sif.ser_out), 8'h0);
    drive(3'd3, 8'h00, 1'b0, 1'b0, 4'd0); tick;
    chk("srl0_q", sif.q, 8'h6D);
    chk("srl0_ser", 8'(sif.ser_out), 8'h0);
    drive(3'd3, 8'h00, 1'b1, 1'b0, 4'd0); tick;
    chk("srl1_q", sif.q, 8'hB6);
    chk("srl1_ser", 8'(sif.ser_out), 8'h1);
    drive(3'd7, 8'h00, 1'b0, 1'b0, 4'd0); tick;
    chk("clr_q", sif.q, 8'h00);
    chk("clr_keeps_ser", 8'(sif.ser_out), 8'h1);
`ifdef SHREG_ZERO_FLAG_EN
    chk("clr_zero", 8'(sif.zero), 8'h1);
`endif
    drive(3'd2, 8'h00, 1'b1, 1'b0, 4'd0);
    tick; tick; tick; tick;
    chk("sll4_q", sif.q, 8'h0F);
`ifdef SHREG_ZERO_FLAG_EN
    chk("sll4_zero", 8'(sif.zero), 8'h0);
`endif
    drive(3'd2, 8'h00, 1'b0, 1'b0, 4'd0); tick;
    chk("sll0_q", sif.q, 8'h1E);
    chk("sll0_ser", 8'(sif.ser_out), 8'h0);
    drive(3'd1, 8'h81, 1'b0, 1'b0, 4'd0); tick;
    chk("load_81", sif.q, 8'h81);
    drive(3'd5, 8'h00, 1'b0, 1'b1, 4'd3); tick;
    chk("rol3_s1_q", sif.q, 8'h03);
    chk("rol3_s1_busy", 8'(sif.busy), 8'h1);
    chk("rol3_s1_done", 8'(sif.done), 8'h0);
    chk("rol3_s1_ser", 8'(sif.ser_out), 8'h1);
    drive(3'd1, 8'hFF, 1'b0, 1'b0, 4'd0); tick;
    chk("rol3_s2_q", sif.q, 8'h06);
    chk("rol3_s2_busy", 8'(sif.busy), 8'h1);
    chk("rol3_s2_done", 8'(sif.done), 8'h0);
    tick;
    chk("rol3_s3_q", sif.q, 8'h0C);
    chk("rol3_s3_busy", 8'(sif.busy), 8'h0);
    chk("rol3_s3_done", 8'(sif.done), 8'h1);
    drive(3'd0, 8'h00, 1'b0, 1'b0, 4'd0); tick;
    chk("rol3_after_done", 8'(sif.done), 8'h0);
    chk("rol3_after_q", sif.q, 8'h0C);
    drive(3'd3, 8'h00, 1'b1, 1'b1, 4'd0); tick;
    chk("amt0_q", sif.q, 8'h0C);
    chk("amt0_done", 8'(sif.done), 8'h1);
    chk("amt0_busy", 8'(sif.busy), 8'h0);
    drive(3'd0, 8'h00, 1'b0, 1'b0, 4'd0); tick;
    chk("amt0_done_clr", 8'(sif.done), 8'h0);
    drive(3'd1, 8'h5A, 1'b0, 1'b1, 4'd3); tick;
    chk("start_load_q", sif.q, 8'h5A);
    chk("start_load_busy", 8'(sif.busy), 8'h0);
    chk("start_load_done", 8'(sif.done), 8'h0);
    drive(3'd2, 8'h00, 1'b0, 1'b1, 4'd1); tick;
    chk("amt1_q", sif.q, 8'hB4);
    chk("amt1_busy", 8'(sif.busy), 8'h0);
    chk("amt1_done", 8'(sif.done), 8'h1);
    drive(3'd1, 8'h01, 1'b0, 1'b0, 4'd0); tick;
    drive(3'd6, 8'h00, 1'b0, 1'b1, 4'd9); tick;
    chk("ror9_s1_q", sif.q, 8'h80);
    drive(3'd0, 8'h00, 1'b0, 1'b0, 4'd0);
    for (int i = 2; i <= 8; i++) begin
      tick;
      chk("ror9_busy", 8'(sif.busy), 8'h1);
      chk("ror9_done", 8'(sif.done), 8'h0);
    end
    chk("ror9_s8_q", sif.q, 8'h01);
    tick;
    chk("ror9_q", sif.q, 8'h80);
    chk("ror9_end_done", 8'(sif.done), 8'h1);
    chk("ror9_end_busy", 8'(sif.busy), 8'h0);
    drive(3'd1, 8'h01, 1'b0, 1'b0, 4'd0); tick;
    drive(3'd5, 8'h00, 1'b0, 1'b1, 4'd5); tick;
    chk("rol5_s1_q", sif.q, 8'h02);
    drive(3'd0, 8'h00, 1'b0, 1'b0, 4'd0); tick;
    chk("rol5_s2_q", sif.q, 8'h04);
    chk("rol5_s2_busy", 8'(sif.busy), 8'h1);
    r = 1'b1; tick;
    chk("abort_q", sif.q, 8'h00);
    chk("abort_busy", 8'(sif.busy), 8'h0);
    chk("abort_done", 8'(sif.done), 8'h0);
    r = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("abort_no_done", 8'(sif.done), 8'h0);
    end
    chk("abort_final_q", sif.q, 8'h00);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/shift_register_param.md
Name: shift_register_param

Overview:
Parametrised successor to the fixed 32-bit load/shift register used in the divider datapath. It provides configurable width and multiple shift modes: logical left/right, arithmetic right, rotate left/right, parallel load and clear. It also adds a multi-cycle "shift by N" command with a busy/done handshake, so the divider controller and future multiplier can issue a whole shift as one request. The block is a drop-in register for the Divisor_v2 and later datapaths.

Parameters:
WIDTH, 32, register width in bits; legal range 2..64.
AMT_W, $clog2(WIDTH)+1, width of the shift-amount port; must hold the value WIDTH.

Ports:
clk  in  1  clock; all state updates on the negative edge of clk (divider datapath convention).
r  in  1  reset, synchronous, active-high; sampled on the same clk edge.
mode  in  3  operation select (encoding below).
load_val  in  WIDTH  parallel load value.
ser_in  in  1  serial input bit for SLL/SRL.
start  in  1  launch a multi-cycle shift of amount steps in the current shift mode.
amount  in  AMT_W  number of single-bit steps for start.
q  out  WIDTH  register contents.
ser_out  out  1  registered copy of the last bit shifted out of q.
busy  out  1  high while a multi-cycle shift is in progress.
done  out  1  one-cycle pulse when a start command completes.

Behaviour:
- Reset (r=1 at the edge): q=0, ser_out=0, busy=0, done=0, step counter=0, latched mode=000. Reset overrides everything, including an in-flight multi-cycle shift, which is abandoned.
- mode encoding:
  - 000 HOLD.
  - 001 LOAD: q<=load_val.
  - 010 SLL: q<={q[W-2:0],ser_in}.
  - 011 SRL: q<={ser_in,q[W-1:1]}.
  - 100 SRA: q<={q[W-1],q[W-1:1]}.
  - 101 ROL.
  - 110 ROR.
  - 111 CLEAR: q<=0.
- Idle (busy=0), start=0: the mode operation executes on every edge. Single-step latency is 1 edge.
- ser_out update: on every shift or rotate step, ser_out takes the bit leaving q (q[W-1] for SLL/ROL, q[0] for SRL/SRA/ROR). LOAD, CLEAR and HOLD leave ser_out unchanged.
- Idle, start=1, mode in 010..110, amount=k:
  - k>=1: the first step executes on the same edge. The controller latches mode and loads counter=k-1. busy<=1 if k>1. Each following edge performs one step and decrements the counter.
  - On the edge that performs step k: busy<=0 and done<=1 for exactly one cycle. Total: k edges, busy high for k-1 cycles.
  - k=0: no step, q unchanged, done pulses on the next edge, busy stays 0.
  - k>WIDTH: the count is honoured literally. Rotate wraps; logical shifts end at all-ser_in or 0; SRA ends at all sign bits.
- Idle, start=1, mode not a shift mode: start is ignored, the mode operation executes as a single step, and no done pulse is produced.
- While busy=1: mode, load_val and start are ignored. The latched mode is used. ser_in is sampled fresh at each step.
- done is 0 in every cycle except the completion cycle. A new start is accepted on the cycle done is high, since busy is already 0.

Optional Feature:
Macro SHREG_ZERO_FLAG_EN.
- Defined: adds output port zero (1 bit). zero is registered; it equals 1 when the value written into q on that edge is all zeros. Reset value 1. It updates with q on every edge, including during busy. The divider uses it for early termination.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
WIDTH=8: r=1 for 2 edges, then release -> q=0x00, ser_out=0, busy=0, done=0 (zero=1 if SHREG_ZERO_FLAG_EN is defined).
WIDTH=8: LOAD 0xB4, then one SRA step -> q=0xDA, ser_out=0. A further SRL step with ser_in=0 -> q=0x6D, ser_out=0.
WIDTH=8: CLEAR, then 4 SLL steps with ser_in=1 -> q=0x0F. One SLL with ser_in=0 -> q=0x1E, ser_out=0.
WIDTH=8: LOAD 0x81, then start ROL amount=3 -> q=0x03, 0x06, 0x0C on successive edges. busy=1 for 2 cycles. done=1 only in the cycle after the third step. mode=LOAD with load_val=0xFF held during busy has no effect.
WIDTH=8: start SRL amount=0 -> q unchanged, done pulses once, busy never asserted. start ROR amount=9 on 0x01 -> q=0x80 after 9 steps.
WIDTH=8: start ROL amount=5 on 0x01, then assert r after 2 steps -> q=0x00, busy=0, done=0 on the reset edge, and no later done pulse.
